// File: rtl/cpu_core_param.sv
// cpu_core_param: four-register CPU with stack, host load port and
// single-cycle execute; HALT/RUN/FAULT control.
module cpu_core_param #(
  parameter  int WIDTH   = 8,
  parameter  int MEMSIZE = 64,
  localparam int AW      = $clog2(MEMSIZE)
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             LOAD_EN,
  input  logic [AW-1:0]    LOAD_ADDR,
  input  logic [WIDTH-1:0] LOAD_DATA,
  output logic [WIDTH-1:0] OUT,
  output logic [AW:0]      IP_OUT,
  output logic             ZF,
  output logic             CF,
  output logic             HALTED,
  output logic             FAULT
);

  localparam logic [1:0] S_HALT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [AW:0]    SP_TOP  = (AW+1)'(MEMSIZE);
  localparam logic [AW:0]    IP_LAST = (AW+1)'(MEMSIZE - 1);
  localparam logic [AW:0]    ONE     = (AW+1)'(1);
  localparam logic [AW:0]    TWO     = (AW+1)'(2);
  localparam logic [WIDTH:0] TGT_LIM = (WIDTH+1)'(MEMSIZE);

  logic [WIDTH-1:0] mem [MEMSIZE];
  logic [WIDTH-1:0] rf [4];
  logic [WIDTH-1:0] rf_n [4];
  logic [WIDTH-1:0] out_q;
  logic [AW:0]      ip, ip_n, sp, sp_n;
  logic             zf, zf_n, cf, cf_n;
  logic [1:0]       state, state_n;

  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;

  logic [7:0]       ir;
  logic [3:0]       op;
  logic [1:0]       dst, src;
  logic [WIDTH-1:0] imm, top, opnd;
  logic [WIDTH:0]   imm_x, top_x, sum, diff;
  logic [AW:0]      ip1, ip2, spm1, spp1;

  logic use_imm, is_push, is_pop, is_ret;
  logic jmp_take, flt;

  assign ip1   = ip + ONE;
  assign ip2   = ip + TWO;
  assign spm1  = sp - ONE;
  assign spp1  = sp + ONE;

  assign ir    = mem[ip[AW-1:0]][7:0];
  assign op    = ir[7:4];
  assign dst   = ir[3:2];
  assign src   = ir[1:0];
  assign imm   = mem[ip1[AW-1:0]];
  assign top   = mem[sp[AW-1:0]];
  assign imm_x = {1'b0, imm};
  assign top_x = {1'b0, top};

  assign opnd  = op[2] ? imm : rf[src];
  assign sum   = {1'b0, rf[dst]} + {1'b0, opnd};
  assign diff  = {1'b0, rf[dst]} - {1'b0, opnd};

  assign use_imm = (op[3:2] == 2'b01) || (op == 4'b1010) ||
                   (op[3:2] == 2'b11 && op != 4'b1111);
  assign is_push = (op == 4'b1000) || (op == 4'b1010);
  assign is_ret  = (op == 4'b1011);
  assign is_pop  = (op == 4'b1001) || is_ret;

  assign jmp_take = (op == 4'b1010) || (op == 4'b1100) ||
                    (op == 4'b1101 && zf) ||
                    (op == 4'b1110 && cf);

  // Every fault cause is resolved before any state is committed.
  assign flt = (ip >= SP_TOP) ||
               (use_imm && ip == IP_LAST) ||
               (is_push && sp == '0) ||
               (is_pop && sp == SP_TOP) ||
               (jmp_take && imm_x >= TGT_LIM) ||
               (is_ret && top_x >= TGT_LIM);

  always_comb begin
    rf_n    = rf;
    ip_n    = ip;
    sp_n    = sp;
    zf_n    = zf;
    cf_n    = cf;
    state_n = state;
    mem_we  = 1'b0;
    mem_wa  = LOAD_ADDR;
    mem_wd  = LOAD_DATA;
    if (LOAD_EN) begin
      mem_we = 1'b1;
    end else if (state == S_HALT) begin
      if (START) begin
        ip_n    = '0;
        sp_n    = SP_TOP;
        state_n = S_RUN;
      end
    end else if (state == S_RUN) begin
      if (flt) begin
        state_n = S_FAULT;
      end else begin
        ip_n = use_imm ? ip2 : ip1;
        unique case (1'b1)
          (!op[3] && op[1:0] == 2'b00): begin
            rf_n[dst] = opnd;
          end
          (!op[3] && op[1:0] == 2'b01): begin
            rf_n[dst] = sum[WIDTH-1:0];
            cf_n      = sum[WIDTH];
            zf_n      = (sum[WIDTH-1:0] == '0);
          end
          (!op[3] && op[1]): begin
            if (!op[0]) rf_n[dst] = diff[WIDTH-1:0];
            cf_n = diff[WIDTH];
            zf_n = (diff[WIDTH-1:0] == '0);
          end
          (op == 4'b1000): begin
            sp_n   = spm1;
            mem_we = 1'b1;
            mem_wa = spm1[AW-1:0];
            mem_wd = rf[src];
          end
          (op == 4'b1001): begin
            rf_n[dst] = top;
            sp_n      = spp1;
          end
          (op == 4'b1010): begin
            sp_n   = spm1;
            mem_we = 1'b1;
            mem_wa = spm1[AW-1:0];
            mem_wd = WIDTH'(ip2);
            ip_n   = imm_x[AW:0];
          end
          (op == 4'b1011): begin
            sp_n = spp1;
            ip_n = top_x[AW:0];
          end
          (op[3:2] == 2'b11 && op != 4'b1111): begin
            if (jmp_take) ip_n = imm_x[AW:0];
          end
          (op == 4'b1111): begin
            ip_n    = ip;
            state_n = S_HALT;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      rf    <= '{default: '0};
      out_q <= '0;
      ip    <= '0;
      sp    <= SP_TOP;
      zf    <= 1'b0;
      cf    <= 1'b0;
      state <= S_HALT;
    end else begin
      rf    <= rf_n;
      out_q <= rf_n[0];
      ip    <= ip_n;
      sp    <= sp_n;
      zf    <= zf_n;
      cf    <= cf_n;
      state <= state_n;
    end
  end

  // Memory survives reset; writes are only blocked while reset is held.
  always_ff @(posedge CLOCK) begin
    if (RESET_N && mem_we) mem[mem_wa] <= mem_wd;
  end

  assign OUT    = out_q;
  assign IP_OUT = ip;
  assign ZF     = zf;
  assign CF     = cf;
  assign HALTED = (state == S_HALT);
  assign FAULT  = (state == S_FAULT);

endmodule

// File: doc/cpu_core_param.md
CPU_CORE_PARAM -- requirements
Module: cpu_core_param

Interface
REQ-001 SHALL have parameter WIDTH, 8, data/register/memory word width in bits (>=8).
REQ-002 SHALL have parameter MEMSIZE, 64, memory depth in words (power of two, 4..256); AW = clog2(MEMSIZE).
REQ-003 SHALL have port CLOCK  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port RESET_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port START  input  1  pulse; HALT -> RUN from ip=0.
REQ-006 SHALL have port LOAD_EN  input  1  memory write strobe from host.
REQ-007 SHALL have port LOAD_ADDR  input  AW  host write address.
REQ-008 SHALL have port LOAD_DATA  input  WIDTH  host write data.
REQ-009 SHALL have port OUT  output  WIDTH  registered copy of register a.
REQ-010 SHALL have port IP_OUT  output  AW+1  current instruction pointer.
REQ-011 SHALL have port ZF / CF  output  1 each  zero and carry flags.
REQ-012 SHALL have port HALTED / FAULT  output  1 each  state decode (HALT / FAULT).

Function
REQ-013 SHALL hold registers a,b,c,d (WIDTH), ip and sp (AW+1), zf, cf, state {HALT, RUN, FAULT}, memory MEMSIZE x WIDTH.
REQ-014 Instruction word low 8 bits SHALL decode as op[7:4], dst[3:2], src[1:0] (00=a,01=b,10=c,11=d); upper bits ignored; immediate, where used, is word at ip+1.
REQ-015 Ops: 0000 mov dst,src; 0001 add; 0010 sub; 0011 cmp; 0100-0111 same four with imm; 1000 push src; 1001 pop dst; 1010 call imm; 1011 ret; 1100 jmp imm; 1101 jz imm; 1110 jc imm; 1111 hlt.
REQ-016 In RUN SHALL execute exactly one instruction per cycle; ip += 1 (reg forms, push, pop) or += 2 (imm forms, untaken jz/jc); taken jump/call sets ip = imm; ret sets ip = popped word.
REQ-017 add/sub SHALL be modulo 2^WIDTH; cf = carry-out (add) or borrow (sub); zf = (result==0); cmp = sub without writeback; mov/push/pop/jumps SHALL not alter flags.
REQ-018 push/call SHALL pre-decrement sp then write mem[sp] (call writes ip+2); pop/ret SHALL read mem[sp] then post-increment sp.
REQ-019 hlt SHALL move state to HALT with ip pointing at the hlt; no further execution until START.
REQ-020 FAULT SHALL be entered, with all registers and memory unchanged by that instruction, on: push/call with sp==0; pop/ret with sp==MEMSIZE; imm fetch with ip==MEMSIZE-1; ip>=MEMSIZE; jump/call/ret target >=MEMSIZE.
REQ-021 FAULT SHALL only be exited by reset; START ignored in FAULT.
REQ-022 START in HALT SHALL set ip=0, sp=MEMSIZE, leave a-d/flags unchanged, state RUN next cycle; START in RUN ignored.
REQ-023 LOAD_EN SHALL write mem[LOAD_ADDR]=LOAD_DATA in any state; in RUN the core SHALL stall that cycle (no execution, no register change).
REQ-024 LOAD_EN and START same cycle: load performed, START ignored.
REQ-025 OUT SHALL equal a after each update (one register, same cycle as a).

Reset
REQ-026 RESET_N low at posedge SHALL set a=b=c=d=OUT=0, ip=0, sp=MEMSIZE, zf=cf=0, state HALT (HALTED=1, FAULT=0), overriding all other inputs incl. mid-instruction.
REQ-027 Reset SHALL not clear memory contents.

Verification (WIDTH=8, MEMSIZE=64)
REQ-028 Load {mov a,#FF; add a,#01; hlt}, START -> after 2 exec cycles a=00, zf=1, cf=1; then HALTED=1, ip=4.
REQ-029 Load {mov a,#05; call 6; hlt; ...; @6: push a; pop b; ret} -> b=05, sp=64, HALTED=1 with ip=4.
REQ-030 Load {pop a} with sp=64 -> FAULT=1 next cycle, a=00, sp=64; START then has no effect; RESET_N low -> HALTED=1.
REQ-031 Program {mov a,#01; sub a,#02; jc 0} -> a=FF, cf=1, ip=0 after jc; jz 0 with zf=0 -> ip += 2.
REQ-032 LOAD_EN asserted in RUN for 3 cycles -> ip, a-d unchanged those cycles; execution resumes after.
REQ-033 RESET_N low while RUN mid-program -> next cycle all registers at reset values, HALTED=1, memory intact.
